// File: rtl/multi_code_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : multi_code_cmp_seq
// Purpose  : Handshaked A/B converter (Binary/Gray/Excess-3/BCD) with magnitude
//            compare; BCD-based codes use a serial double-dabble engine.
// Revision : 1.0 - initial release
// ============================================================================
module multi_code_cmp_seq #(
   parameter  int WIDTH = 8,
   localparam int NDIG  = (WIDTH * 302) / 1000 + 1,
   localparam int OUT_W = 4 * NDIG
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] convA,
   output logic [OUT_W-1:0] convB,
   output logic [1:0]       mode_o,
   output logic             gt,
   output logic             lt,
   output logic             eq,
   output logic             busy
);

   localparam int                   c_STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_STEP_W-1:0]  c_LAST   = c_STEP_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t              r_state, w_state_next;
   logic                w_accept;
   logic [WIDTH-1:0]    r_op_a, r_op_b;
   logic [OUT_W-1:0]    r_scr_a, r_scr_b;
   logic [OUT_W-1:0]    w_scr_a_next, w_scr_b_next;
   logic [c_STEP_W-1:0] r_step;
   logic                r_xs3;

   // all=1 adds 3 to every digit (Excess-3); all=0 is the dabble correction.
   function automatic logic [OUT_W-1:0] adj_digits(input logic [OUT_W-1:0] v,
                                                   input logic all);
      logic [OUT_W-1:0] r;
      r = v;
      for (int i = 0; i < NDIG; i++) begin
         if (all || (v[4*i +: 4] >= 4'd5))
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_comb begin
      w_scr_a_next = adj_digits(r_scr_a, 1'b0);
      w_scr_b_next = adj_digits(r_scr_b, 1'b0);
      w_scr_a_next = {w_scr_a_next[OUT_W-2:0], r_op_a[WIDTH-1]};
      w_scr_b_next = {w_scr_b_next[OUT_W-2:0], r_op_b[WIDTH-1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = (r_state == IDLE) || ((r_state == OUT) && out_ready);
      w_accept     = in_valid && in_ready;
      out_valid    = (r_state == OUT);
      busy         = (r_state != IDLE);
      case (r_state)
         IDLE: if (w_accept) w_state_next = mode[1] ? CONV : OUT;
         CONV: if (r_step == c_LAST) w_state_next = OUT;
         OUT: begin
            if (w_accept)       w_state_next = mode[1] ? CONV : OUT;
            else if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_scr_a <= '0;
         r_scr_b <= '0;
         r_step  <= '0;
         r_xs3   <= 1'b0;
         convA   <= '0;
         convB   <= '0;
         mode_o  <= '0;
         gt      <= 1'b0;
         lt      <= 1'b0;
         eq      <= 1'b0;
      end else if (w_accept) begin
         r_op_a  <= A;
         r_op_b  <= B;
         r_scr_a <= '0;
         r_scr_b <= '0;
         r_step  <= '0;
         r_xs3   <= ~mode[0];
         mode_o  <= mode;
         gt      <= (A > B);
         lt      <= (A < B);
         eq      <= (A == B);
         // Binary and Gray complete here; BCD codes are loaded after the last step.
         if (!mode[1]) begin
            convA <= mode[0] ? OUT_W'(A ^ (A >> 1)) : OUT_W'(A);
            convB <= mode[0] ? OUT_W'(B ^ (B >> 1)) : OUT_W'(B);
         end
      end else if (r_state == CONV) begin
         r_scr_a <= w_scr_a_next;
         r_scr_b <= w_scr_b_next;
         r_op_a  <= r_op_a << 1;
         r_op_b  <= r_op_b << 1;
         r_step  <= r_step + c_STEP_W'(1);
         if (r_step == c_LAST) begin
            convA <= adj_digits(w_scr_a_next, 1'b1) & {OUT_W{r_xs3}}
                   | w_scr_a_next & {OUT_W{~r_xs3}};
            convB <= adj_digits(w_scr_b_next, 1'b1) & {OUT_W{r_xs3}}
                   | w_scr_b_next & {OUT_W{~r_xs3}};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_code_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_code_cmp_seq
// Purpose  : Self-checking bench: directed vector table, handshake corner
//            sequences and randomized requests against a decimal-digit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_code_cmp_seq;

   localparam int WIDTH = 8;
   localparam int NDIG  = 3;
   localparam int OUT_W = 12;

   logic             clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] A, B;
   logic [1:0]       mode, mode_o;
   logic [OUT_W-1:0] convA, convB;
   logic             gt, lt, eq, busy;

   int n_checks = 0;
   int n_fail   = 0;

   multi_code_cmp_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .convA(convA), .convB(convB), .mode_o(mode_o),
      .gt(gt), .lt(lt), .eq(eq), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a, b;
      logic [1:0]  m;
      logic [11:0] ea, eb;
      logic        egt, elt, eeq;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference conversion from decimal digits, independent of any shift engine.
   function automatic logic [11:0] ref_conv(input int x, input logic [1:0] m);
      logic [11:0] r;
      int v;
      r = '0;
      v = x;
      case (m)
         2'b00: r = 12'(x);
         2'b01: r = 12'(x ^ (x / 2));
         default: begin
            for (int i = 0; i < NDIG; i++) begin
               r = r | (12'((v % 10) + ((m == 2'b10) ? 3 : 0)) << (4 * i));
               v = v / 10;
            end
         end
      endcase
      return r;
   endfunction

   // Called at a negedge with the DUT idle; leaves the DUT idle at a negedge.
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                          input logic [11:0] ea, input logic [11:0] eb,
                          input logic egt, input logic elt, input logic eeq, input int elat);
      int lat;
      in_valid = 1'b1; A = a; B = b; mode = m; out_ready = 1'b0;
      #1 check("in_ready_idle", in_ready, 1);
      @(posedge clk);
      #1;
      lat = 0;
      do begin
         in_valid = 1'($urandom); A = 8'($urandom); B = 8'($urandom); mode = 2'($urandom);
         @(negedge clk);
         lat++;
         if (!out_valid) check("busy_conv", busy, 1);
      end while (!out_valid && lat < 40);
      check("latency", lat, elat);
      check("convA", convA, ea);
      check("convB", convB, eb);
      check("mode_o", mode_o, m);
      check("gt", gt, egt);
      check("lt", lt, elt);
      check("eq", eq, eeq);
      check("in_ready_held", in_ready, 0);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("out_valid_drop", out_valid, 0);
      check("busy_idle", busy, 0);
      out_ready = 1'b0;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'd6,   8'd3,   2'b00, 12'h006, 12'h003, 1'b1, 1'b0, 1'b0, 1};
      vecs[1] = '{8'd5,   8'd7,   2'b01, 12'h007, 12'h004, 1'b0, 1'b1, 1'b0, 1};
      vecs[2] = '{8'd2,   8'd6,   2'b10, 12'h335, 12'h339, 1'b0, 1'b1, 1'b0, 9};
      vecs[3] = '{8'd200, 8'd99,  2'b11, 12'h200, 12'h099, 1'b1, 1'b0, 1'b0, 9};
      vecs[4] = '{8'd255, 8'd255, 2'b11, 12'h255, 12'h255, 1'b0, 1'b0, 1'b1, 9};
      vecs[5] = '{8'd0,   8'd0,   2'b10, 12'h333, 12'h333, 1'b0, 1'b0, 1'b1, 9};

      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; mode = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_conv", {convA, convB, mode_o, gt, lt, eq}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      for (int i = 0; i < 6; i++)
         run_txn(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].ea, vecs[i].eb,
                 vecs[i].egt, vecs[i].elt, vecs[i].eeq, vecs[i].lat);

      // Backpressure on a Gray result, then back-to-back accept on release.
      in_valid = 1'b1; A = 8'd5; B = 8'd7; mode = 2'b01; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1; A = 8'($urandom); B = 8'($urandom);
         check("bp_valid", out_valid, 1);
         check("bp_convA", convA, 12'h007);
         check("bp_convB", convB, 12'h004);
         check("bp_lt", lt, 1);
         #1 check("bp_in_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; A = 8'd6; B = 8'd3; mode = 2'b00;
      #1 check("b2b_in_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_convA", convA, 12'h006);
      check("b2b_convB", convB, 12'h003);
      check("b2b_gt", gt, 1);
      @(negedge clk);
      out_ready = 1'b0;
      check("b2b_idle", busy, 0);

      // Reset during conversion discards the pending result.
      in_valid = 1'b1; A = 8'd123; B = 8'd45; mode = 2'b11;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_outs", {convA, convB, mode_o, gt, lt, eq}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check("midrst_no_valid", out_valid, 0);
      end
      check("midrst_ready", in_ready, 1);

      for (int t = 0; t < 30; t++) begin
         logic [7:0] ra, rb;
         logic [1:0] rm;
         ra = 8'($urandom); rb = 8'($urandom); rm = 2'($urandom);
         if (t % 7 == 0) rb = ra;
         run_txn(ra, rb, rm, ref_conv(int'(ra), rm), ref_conv(int'(rb), rm),
                 ra > rb, ra < rb, ra == rb, rm[1] ? WIDTH + 1 : 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
